// File: rtl/controle_reservatorio.sv
// Tank refill controller: debounces the H/M/L level sensors, runs the inlet-valve refill FSM
// with a fill timeout, reports the level and gates irrigation draws.
module controle_reservatorio #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned FILL_TIMEOUT = 1000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       H,
  input  logic       M,
  input  logic       L,
  input  logic       Bs,
  input  logic       Vs,
  input  logic       clr_err,
  output logic       Ve,
  output logic       irr_ok,
  output logic       err,
  output logic [1:0] err_code,
  output logic [1:0] nivel,
  output logic       bloqueio
);

  localparam int unsigned      DebW      = $clog2(DEB_CYCLES + 1);
  localparam logic [DebW-1:0]  DebLast   = DebW'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimerLast = CNT_W'(FILL_TIMEOUT - 1);

  typedef enum logic [1:0] {StOcioso, StEnchendo, StErro} state_e;

  // Sensor vectors are ordered {H, M, L}.
  logic [2:0]      raw;
  logic [2:0]      filt_q, filt_d;
  logic [DebW-1:0] deb_cnt_q [3];
  logic [DebW-1:0] deb_cnt_d [3];

  assign raw = {H, M, L};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      filt_d[i]    = filt_q[i];
      deb_cnt_d[i] = '0;
      if (raw[i] != filt_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          filt_d[i] = raw[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  logic       consistent;
  logic [1:0] level;

  // Only thermometer-coded patterns are physically possible with a healthy sensor stack.
  always_comb begin
    consistent = 1'b1;
    level      = 2'b00;
    unique case (filt_q)
      3'b000:  level = 2'b00;
      3'b001:  level = 2'b01;
      3'b011:  level = 2'b10;
      3'b111:  level = 2'b11;
      default: consistent = 1'b0;
    endcase
  end

  state_e           state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             irr_ok_q, bloq_q, ve_q, err_q;
  logic [1:0]       nivel_q;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    timer_d = timer_q;
    if (!consistent) begin
      // Sensor inconsistency outranks a timeout on the same edge.
      state_d = StErro;
      code_d  = 2'b01;
    end else begin
      unique case (state_q)
        StOcioso: begin
          if (!filt_q[1]) begin
            state_d = StEnchendo;
            timer_d = '0;
          end
        end
        StEnchendo: begin
          if (filt_q[2]) begin
            state_d = StOcioso;
          end else if (timer_q == TimerLast) begin
            state_d = StErro;
            code_d  = 2'b10;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StErro: begin
          if (clr_err) begin
            state_d = StOcioso;
            code_d  = 2'b00;
          end
        end
        default: state_d = StOcioso;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StOcioso;
      code_q   <= 2'b00;
      timer_q  <= '0;
      ve_q     <= 1'b0;
      err_q    <= 1'b0;
      irr_ok_q <= 1'b0;
      nivel_q  <= 2'b00;
      bloq_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      timer_q  <= timer_d;
      ve_q     <= (state_d == StEnchendo);
      err_q    <= (state_d == StErro);
      irr_ok_q <= (state_d != StErro) && filt_q[0];
      if (consistent) begin
        nivel_q <= level;
      end
      if ((Bs || Vs) && !irr_ok_q) begin
        bloq_q <= 1'b1;
      end else if (clr_err) begin
        bloq_q <= 1'b0;
      end
    end
  end

  assign Ve       = ve_q;
  assign err      = err_q;
  assign err_code = code_q;
  assign irr_ok   = irr_ok_q;
  assign nivel    = nivel_q;
  assign bloqueio = bloq_q;

endmodule
